instruction_fetch_unit: RTL and testbench

Multicycle instruction fetch stage that sits directly upstream of the immediate block and the rest of decode. It owns the fetch program counter, issues one word read per instruction to instruction memory over a req/ack handshake, and latches the returned word into `IR`, which is then held stable for decode. It also accepts branch/jump redirects from execute. It detects misaligned redirect targets and memory timeouts, and signals both through a sticky fault.

---
 rtl/instruction_fetch_unit.sv | 107 ++++++++++
 tb/tb_instruction_fetch_unit.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_unit.sv
// Multicycle instruction fetch: owns the fetch PC, reads one word per instruction
// over a req/ack handshake, holds it in IR for decode, and accepts execute redirects.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic [31:0] IR,
  output logic        ir_valid,
  output logic [31:0] PC,
  output logic [31:0] PC_plus4,
  output logic        fault
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    FAULT
  } state_t;

  localparam logic [15:0] TIMEOUT_LIM = 16'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] cnt_inc;

  assign cnt_inc = cnt_q + 16'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      fetch_pc_q <= RESET_PC;
      ir_q       <= '0;
      pc_q       <= RESET_PC;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      ir_q       <= ir_d;
      pc_q       <= pc_d;
      cnt_q      <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    ir_d       = ir_q;
    pc_d       = pc_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        // An ack on the limit cycle takes priority over the timeout.
        if (mem_ack) begin
          ir_d       = mem_rdata;
          pc_d       = fetch_pc_q;
          fetch_pc_d = fetch_pc_q + 32'd4;
          cnt_d      = '0;
          state_d    = HOLD;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TIMEOUT_LIM) state_d = FAULT;
        end
      end
      HOLD: begin
        if (!stall) begin
          if (branch_taken) begin
            if (branch_target[1:0] == 2'b00) begin
              fetch_pc_d = branch_target;
              state_d    = REQ;
            end else begin
              state_d = FAULT;
            end
          end else begin
            state_d = REQ;
          end
        end
      end
      FAULT: state_d = FAULT;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_req  = (state_q == REQ);
    ir_valid = (state_q == HOLD);
    fault    = (state_q == FAULT);
    mem_addr = fetch_pc_q;
    IR       = ir_q;
    PC       = pc_q;
    PC_plus4 = pc_q + 32'd4;
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: fetch, stall, branch, timeout,
// wrap, asynchronous reset and misaligned-redirect fault.
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic [31:0] IR;
  logic        ir_valid;
  logic [31:0] PC;
  logic [31:0] PC_plus4;
  logic        fault;

  int errors = 0;
  int checks = 0;

  instruction_fetch_unit #(
    .RESET_PC      (32'h0000_0000),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .stall        (stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .mem_ack      (mem_ack),
    .mem_rdata    (mem_rdata),
    .IR           (IR),
    .ir_valid     (ir_valid),
    .PC           (PC),
    .PC_plus4     (PC_plus4),
    .fault        (fault)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset values
    #2;
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_ir_valid", 32'(ir_valid), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_IR", IR, 32'h0);
    check("rst_PC", PC, 32'h0);
    check("rst_PC_plus4", PC_plus4, 32'h4);
    check("rst_mem_addr", mem_addr, 32'h0);
    tick();
    reset = 1'b0;

    // Cycle 0 is IDLE, first request in cycle 1
    check("idle_mem_req", 32'(mem_req), 32'd0);
    tick();
    check("req0_mem_req", 32'(mem_req), 32'd1);
    check("req0_addr", mem_addr, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'h1234_5678;
    tick();
    mem_ack = 1'b0;
    check("f0_IR", IR, 32'h1234_5678);
    check("f0_PC", PC, 32'h0);
    check("f0_PC_plus4", PC_plus4, 32'h4);
    check("f0_ir_valid", 32'(ir_valid), 32'd1);
    check("f0_mem_req", 32'(mem_req), 32'd0);

    // Stall for 3 HOLD cycles, consume on the 4th
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("stall_IR", IR, 32'h1234_5678);
      check("stall_ir_valid", 32'(ir_valid), 32'd1);
      tick();
    end
    stall = 1'b0;
    check("stall_IR4", IR, 32'h1234_5678);
    check("stall_mem_req4", 32'(mem_req), 32'd0);
    tick();
    check("seq_mem_req", 32'(mem_req), 32'd1);
    check("seq_addr", mem_addr, 32'h4);
    mem_ack = 1'b1; mem_rdata = 32'hA0A0_0001;
    tick();
    mem_ack = 1'b0;
    check("f1_PC", PC, 32'h4);
    check("f1_IR", IR, 32'hA0A0_0001);

    // Redirect while stalled is ignored
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h0000_0100;
    tick();
    check("br_stall_valid", 32'(ir_valid), 32'd1);
    check("br_stall_req", 32'(mem_req), 32'd0);
    check("br_stall_PC", PC, 32'h4);
    stall = 1'b0;
    tick();
    branch_taken = 1'b0;
    check("br_mem_req", 32'(mem_req), 32'd1);
    check("br_addr", mem_addr, 32'h100);
    mem_ack = 1'b1; mem_rdata = 32'hB0B0_0002;
    tick();
    mem_ack = 1'b0;
    check("br_PC", PC, 32'h100);
    check("br_PC_plus4", PC_plus4, 32'h104);
    check("br_IR", IR, 32'hB0B0_0002);

    // Ack on the 4th REQ cycle beats the timeout
    tick();
    check("to_ack_addr", mem_addr, 32'h104);
    tick(); tick(); tick();
    check("to_ack_req4", 32'(mem_req), 32'd1);
    check("to_ack_fault4", 32'(fault), 32'd0);
    mem_ack = 1'b1; mem_rdata = 32'hC0C0_0003;
    tick();
    mem_ack = 1'b0;
    check("to_ack_fault", 32'(fault), 32'd0);
    check("to_ack_valid", 32'(ir_valid), 32'd1);
    check("to_ack_PC", PC, 32'h104);

    // Redirect to the last word, then the sequential fetch wraps to 0
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFC;
    tick();
    branch_taken = 1'b0;
    check("wrap_addr0", mem_addr, 32'hFFFF_FFFC);
    mem_ack = 1'b1; mem_rdata = 32'hD0D0_0004;
    tick();
    mem_ack = 1'b0;
    check("wrap_PC", PC, 32'hFFFF_FFFC);
    check("wrap_PC_plus4", PC_plus4, 32'h0);
    tick();
    check("wrap_mem_req", 32'(mem_req), 32'd1);
    check("wrap_addr1", mem_addr, 32'h0);

    // No ack: fault after exactly 4 REQ cycles
    tick(); tick();
    check("to_req3_fault", 32'(fault), 32'd0);
    tick();
    check("to_req4_req", 32'(mem_req), 32'd1);
    check("to_req4_fault", 32'(fault), 32'd0);
    tick();
    check("to_fault", 32'(fault), 32'd1);
    check("to_fault_req", 32'(mem_req), 32'd0);
    check("to_fault_valid", 32'(ir_valid), 32'd0);
    check("to_fault_IR", IR, 32'hD0D0_0004);
    mem_ack = 1'b1; mem_rdata = 32'hEEEE_EEEE;
    tick();
    mem_ack = 1'b0;
    check("to_sticky_fault", 32'(fault), 32'd1);
    check("to_sticky_IR", IR, 32'hD0D0_0004);

    // Asynchronous reset in the middle of a request
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("ar_req_before", 32'(mem_req), 32'd1);
    #2;
    reset = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    #1;
    check("ar_mem_req", 32'(mem_req), 32'd0);
    check("ar_fault", 32'(fault), 32'd0);
    check("ar_IR", IR, 32'h0);
    tick();
    reset = 1'b0; mem_ack = 1'b0;
    check("ar_idle_req", 32'(mem_req), 32'd0);
    check("ar_idle_valid", 32'(ir_valid), 32'd0);
    tick();
    check("ar_req_addr", mem_addr, 32'h0);
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    tick();
    mem_ack = 1'b0;
    check("ar_IR_after", IR, 32'hCAFE_F00D);

    // Misaligned redirect target faults and freezes IR/PC
    branch_taken = 1'b1; branch_target = 32'h0000_0102;
    tick();
    branch_taken = 1'b0;
    check("mis_fault", 32'(fault), 32'd1);
    check("mis_valid", 32'(ir_valid), 32'd0);
    check("mis_req", 32'(mem_req), 32'd0);
    check("mis_IR", IR, 32'hCAFE_F00D);
    check("mis_PC", PC, 32'h0);
    tick(); tick();
    check("mis_IR_hold", IR, 32'hCAFE_F00D);
    check("mis_fault_hold", 32'(fault), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
